// File: rtl/router_merge_acc.sv
// Quadtree router merge stage: holds one UV packet per child, then sums the set into one
// registered valid/ready output once all addresses agree. Mismatches and non-UV packets are dropped and counted.
module router_merge_acc #(
   parameter int                    NUM_CHILD  = 4,
   parameter int                    INFO_WIDTH = 4,
   parameter int                    ADDR_WIDTH = 16,
   parameter int                    DATA_WIDTH = 16,
   parameter logic [INFO_WIDTH-1:0] INFO_UV    = 4'd3,
   parameter bit                    SAT        = 1'b0
) (
   input  logic                                            clk,
   input  logic                                            rst_n,
   input  logic [NUM_CHILD-1:0]                            in_valid,
   input  logic [NUM_CHILD*(INFO_WIDTH+ADDR_WIDTH+DATA_WIDTH)-1:0] in_data,
   output logic [NUM_CHILD-1:0]                            in_ready,
   output logic                                            out_valid,
   output logic [INFO_WIDTH+ADDR_WIDTH+DATA_WIDTH-1:0]     out_data,
   input  logic                                            out_ready,
   output logic                                            err_mismatch,
   output logic [15:0]                                     drop_cnt
);

   localparam int PW = INFO_WIDTH + ADDR_WIDTH + DATA_WIDTH;
   localparam int HW = ADDR_WIDTH + DATA_WIDTH;
   localparam int SW = DATA_WIDTH + $clog2(NUM_CHILD);
   localparam int CW = $clog2(NUM_CHILD + 2);
   localparam logic signed [SW-1:0] MAXV = {{(SW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [SW-1:0] MINV = {{(SW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   // Only address and data are kept; info is always INFO_UV once held.
   logic [NUM_CHILD-1:0]    r_held;
   logic [HW-1:0]           r_hold_pkt [NUM_CHILD];

   logic [NUM_CHILD-1:0]    w_hs;
   logic [NUM_CHILD-1:0]    w_is_uv;
   logic                    w_all_held;
   logic                    w_addr_eq;
   logic                    w_out_free;
   logic                    w_fire;
   logic                    w_mismatch;
   logic [CW-1:0]           w_drops;
   logic [16:0]             w_drop_sum;
   logic signed [SW-1:0]    w_sum;
   logic [DATA_WIDTH-1:0]   w_sum_out;

   assign w_all_held = &r_held;
   assign w_out_free = !out_valid || out_ready;
   assign w_fire     = w_all_held && w_addr_eq && w_out_free;
   assign w_mismatch = w_all_held && !w_addr_eq;
   assign in_ready   = ~r_held | {NUM_CHILD{w_fire | w_mismatch}};
   assign w_hs       = in_valid & in_ready;
   assign w_drop_sum = {1'b0, drop_cnt} + 17'(w_drops);

   // NOTE: every always_comb output gets a default before any conditional update, so no latch can be inferred.
   always_comb begin
      w_addr_eq = 1'b1;
      w_drops   = CW'(w_mismatch);
      w_sum     = '0;
      for (int i = 0; i < NUM_CHILD; i++) begin
         w_is_uv[i] = (in_data[i*PW + PW - 1 -: INFO_WIDTH] == INFO_UV);
         w_drops    = w_drops + CW'(w_hs[i] & ~w_is_uv[i]);
         w_sum      = w_sum + SW'($signed(r_hold_pkt[i][DATA_WIDTH-1:0]));
         if (r_hold_pkt[i][HW-1 -: ADDR_WIDTH] != r_hold_pkt[0][HW-1 -: ADDR_WIDTH])
            w_addr_eq = 1'b0;
      end
      if (SAT && (w_sum > MAXV))
         w_sum_out = MAXV[DATA_WIDTH-1:0];
      else if (SAT && (w_sum < MINV))
         w_sum_out = MINV[DATA_WIDTH-1:0];
      else
         w_sum_out = w_sum[DATA_WIDTH-1:0];
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_held       <= '0;
         out_valid    <= 1'b0;
         out_data     <= '0;
         err_mismatch <= 1'b0;
         drop_cnt     <= '0;
      end else begin
         // A new capture on the clearing edge wins over the clear.
         r_held       <= (r_held & ~{NUM_CHILD{w_fire | w_mismatch}}) | (w_hs & w_is_uv);
         err_mismatch <= w_mismatch;
         drop_cnt     <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
         if (w_fire) begin
            out_valid <= 1'b1;
            out_data  <= {INFO_UV, r_hold_pkt[0][HW-1 -: ADDR_WIDTH], w_sum_out};
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   // NOTE: holding registers are not reset; r_held qualifies them, so their reset value never matters.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CHILD; i++)
         if (w_hs[i] && w_is_uv[i])
            r_hold_pkt[i] <= in_data[i*PW +: HW];
   end

endmodule

// File: tb/tb_router_merge_acc.sv
// Self-checking bench for router_merge_acc: directed scenarios then random traffic, with wrap and
// saturating instances driven in parallel and compared against a behavioural reference model.
module tb_router_merge_acc;

   localparam int NC = 4;
   localparam int PW = 36;
   localparam logic [3:0] UV = 4'd3;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [NC-1:0]   in_valid = '0;
   logic [NC*PW-1:0] in_data = '0;
   logic            out_ready = 1'b0;
   logic [NC-1:0]   rdy0, rdy1;
   logic            ov0, ov1, err0, err1;
   logic [PW-1:0]   od0, od1;
   logic [15:0]     dc0, dc1;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic            m_held [NC];
   logic [15:0]     m_addr [NC];
   logic [15:0]     m_data [NC];
   logic            m_ov = 1'b0, m_err = 1'b0;
   logic [PW-1:0]   m_od0 = '0, m_od1 = '0;
   int              m_drop = 0;

   always #5 clk = ~clk;

   router_merge_acc #(.SAT(1'b0)) u_wrap (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy0),
      .out_valid(ov0), .out_data(od0), .out_ready(out_ready), .err_mismatch(err0), .drop_cnt(dc0));

   router_merge_acc #(.SAT(1'b1)) u_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy1),
      .out_valid(ov1), .out_data(od1), .out_ready(out_ready), .err_mismatch(err1), .drop_cnt(dc1));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [PW-1:0] pkt(input logic [3:0] info, input logic [15:0] a, input logic [15:0] d);
      return {info, a, d};
   endfunction

   function automatic logic [NC*PW-1:0] uv4(input logic [15:0] a, input logic [15:0] d0, d1, d2, d3);
      return {pkt(UV, a, d3), pkt(UV, a, d2), pkt(UV, a, d1), pkt(UV, a, d0)};
   endfunction

   // One clock: check registered outputs, drive inputs, check in_ready, then advance the model.
   task automatic cycle(input logic rst, input logic [NC-1:0] vld, input logic [NC*PW-1:0] dat, input logic ordy);
      logic [PW-1:0] p;
      logic [NC-1:0] rdy;
      bit all_h, eq, fire, mm;
      int drops, s;
      logic [31:0] su;
      @(negedge clk);
      check("out_valid", ov0, m_ov);
      check("out_valid_sat", ov1, m_ov);
      check("out_data", od0, m_od0);
      check("out_data_sat", od1, m_od1);
      check("err_mismatch", err0, m_err);
      check("err_mismatch_sat", err1, m_err);
      check("drop_cnt", dc0, m_drop);
      check("drop_cnt_sat", dc1, m_drop);
      rst_n = rst; in_valid = vld; in_data = dat; out_ready = ordy;
      #1;
      all_h = 1; eq = 1;
      for (int i = 0; i < NC; i++) begin
         all_h = all_h && m_held[i];
         eq    = eq && (m_addr[i] == m_addr[0]);
      end
      fire = all_h && eq && (!m_ov || ordy);
      mm   = all_h && !eq;
      for (int i = 0; i < NC; i++) rdy[i] = !m_held[i] || fire || mm;
      check("in_ready", rdy0, rdy);
      check("in_ready_sat", rdy1, rdy);
      s = 0;
      for (int i = 0; i < NC; i++) s += int'($signed(m_data[i]));
      su = s;
      @(posedge clk);
      if (!rst) begin
         for (int i = 0; i < NC; i++) m_held[i] = 1'b0;
         m_ov = 0; m_od0 = '0; m_od1 = '0; m_err = 0; m_drop = 0;
      end else begin
         drops = mm ? 1 : 0;
         if (fire) begin
            m_ov  = 1;
            m_od0 = {UV, m_addr[0], su[15:0]};
            m_od1 = {UV, m_addr[0], (s > 32767) ? 16'h7FFF : (s < -32768) ? 16'h8000 : su[15:0]};
         end else if (ordy) m_ov = 0;
         for (int i = 0; i < NC; i++) begin
            if (fire || mm) m_held[i] = 1'b0;
            p = dat[i*PW +: PW];
            if (vld[i] && rdy[i]) begin
               if (p[PW-1 -: 4] == UV) begin
                  m_held[i] = 1'b1; m_addr[i] = p[31:16]; m_data[i] = p[15:0];
               end else drops++;
            end
         end
         m_err  = mm;
         m_drop = (m_drop + drops > 65535) ? 65535 : m_drop + drops;
      end
   endtask

   task automatic idle(input logic ordy);
      cycle(1'b1, '0, '0, ordy);
   endtask

   initial begin
      logic [NC*PW-1:0] rd;
      logic [NC-1:0]    rv;
      logic [3:0]       info;
      logic [15:0]      a, d;
      int               mode;
      for (int i = 0; i < NC; i++) begin m_held[i] = 0; m_addr[i] = '0; m_data[i] = '0; end
      @(posedge clk);   // reset edge with rst_n low

      // aligned merge
      cycle(1, 4'hF, uv4(16'h0055, 1, 2, 3, 4), 1);
      idle(1);
      #1 check("aligned_valid", ov0, 1'b1);
      check("aligned_data", od0, {UV, 16'h0055, 16'h000A});

      // skewed arrival of child 2
      cycle(1, 4'b1011, uv4(16'h0070, 10, 20, 30, 40), 1);
      #1 check("skew_ready", rdy0, 4'b0100);
      repeat (4) idle(1);
      cycle(1, 4'b0100, uv4(16'h0070, 10, 20, 30, 40), 1);
      idle(1);
      #1 check("skew_data", od0, {UV, 16'h0070, 16'h0064});

      // saturation vs wrap
      cycle(1, 4'hF, uv4(16'h0001, 16'h7000, 16'h7000, 16'h7000, 16'h7000), 1);
      idle(1);
      #1 check("wrap_pos", od0[15:0], 16'hC000);
      check("sat_pos", od1[15:0], 16'h7FFF);
      cycle(1, 4'hF, uv4(16'h0002, 16'h8000, 16'h8000, 16'h8000, 16'h8000), 1);
      idle(1);
      #1 check("wrap_neg", od0[15:0], 16'h0000);
      check("sat_neg", od1[15:0], 16'h8000);

      // backpressure with a second set queued behind the output
      cycle(1, 4'hF, uv4(16'h0010, 1, 2, 3, 4), 1);
      idle(1);
      repeat (4) cycle(1, 4'hF, uv4(16'h0020, 5, 6, 7, 8), 0);
      #1 check("bp_ready", rdy0, 4'b0000);
      check("bp_stable", od0, {UV, 16'h0010, 16'h000A});
      idle(1);
      #1 check("bp_second", od0, {UV, 16'h0020, 16'h001A});

      // address mismatch, then two simultaneous non-UV drops
      cycle(1, 4'hF, {pkt(UV, 16'h0056, 1), pkt(UV, 16'h0055, 1), pkt(UV, 16'h0055, 1), pkt(UV, 16'h0055, 1)}, 1);
      idle(1);
      #1 check("mm_err", err0, 1'b1);
      check("mm_drop", dc0, 16'd1);
      check("mm_noout", ov0, 1'b0);
      cycle(1, 4'b0011, {pkt(UV, 16'h0055, 0), pkt(UV, 16'h0055, 0), pkt(4'd5, 16'h0055, 0), pkt(4'd5, 16'h0055, 0)}, 1);
      #1 check("nonuv_drop", dc0, 16'd3);

      // reset mid-operation
      cycle(1, 4'hF, uv4(16'h0030, 1, 1, 1, 1), 0);
      cycle(1, 4'b0111, uv4(16'h0031, 2, 2, 2, 2), 0);
      #1 check("pre_rst_valid", ov0, 1'b1);
      cycle(0, '0, '0, 0);
      #1 check("rst_valid", ov0, 1'b0);
      check("rst_drop", dc0, 16'd0);
      check("rst_ready", rdy0, 4'hF);
      cycle(1, 4'hF, uv4(16'h0040, 1, 1, 1, 1), 1);
      idle(1);
      #1 check("post_rst_data", od0, {UV, 16'h0040, 16'h0004});

      // random traffic
      for (int c = 0; c < 4000; c++) begin
         mode = $urandom_range(3);
         for (int i = 0; i < NC; i++) begin
            rv[i] = ($urandom_range(9) < 6);
            info  = ($urandom_range(11) == 0) ? 4'($urandom) : UV;
            a     = ($urandom_range(15) == 0) ? 16'h0056 : 16'h0055;
            case (mode)
               0: d = 16'($urandom);
               1: d = 16'h6000 + 16'($urandom_range(16'h1FFF));
               2: d = 16'h8000 + 16'($urandom_range(16'h0FFF));
               default: d = 16'($urandom_range(15));
            endcase
            rd[i*PW +: PW] = pkt(info, a, d);
         end
         cycle(($urandom_range(499) != 0), rv, rd, ($urandom_range(3) != 0));
      end
      idle(1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/router_merge_acc.md
# router_merge_acc

Parametrised, pipelined merge stage for the quadtree router. It collects one UV packet from each of `NUM_CHILD` child directions, which may arrive in different cycles, and buffers each in a one-entry holding register. Once all are held with matching address fields, it emits a single summed UV packet through a registered valid/ready output. It sits between the switch-traversal outputs of the child ports and the parent-bound output port. It adds the arrival skew tolerance, backpressure, selectable saturating arithmetic and error accounting that the purely combinational merge stage lacks.

## Interface
- `NUM_CHILD`, 4: number of merged child directions (≥2).
- `INFO_WIDTH`, 4: packet info field width.
- `ADDR_WIDTH`, 16: packet address/index field width.
- `DATA_WIDTH`, 16: packet data field width; two's complement.
- `INFO_UV`, 4'd3: info code marking a mergeable UV packet.
- `SAT`, 0: 1 = saturating sum, 0 = wrap (truncate).
- Packet layout, `PW = INFO_WIDTH+ADDR_WIDTH+DATA_WIDTH`: `[PW-1 -: INFO_WIDTH]` info, then address, then `[DATA_WIDTH-1:0]` data.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; one clock, synchronous, active-low.
- `in_valid`  in  NUM_CHILD  per-child packet valid.
- `in_data`  in  NUM_CHILD*PW  packed child packets; child i at `[i*PW +: PW]`.
- `in_ready`  out  NUM_CHILD  per-child ready.
- `out_valid`  out  1  merged packet valid.
- `out_data`  out  PW  merged packet.
- `out_ready`  in  1  downstream ready.
- `err_mismatch`  out  1  one-cycle pulse on an address mismatch.
- `drop_cnt`  out  16  saturating count of drop events.

## Operation
- Per child i: `held[i]` flag and `hold_pkt[i]` register.
- A handshake occurs when `in_valid[i] && in_ready[i]`. On handshake:
  - info == `INFO_UV`: store the packet and set `held[i]`.
  - Otherwise: discard the packet; count one drop event; `held[i]` is unchanged.
- `all_held` = AND of `held`. `addr_eq` = all held address fields are equal to child 0's.
- `out_free` = `!out_valid || out_ready`.
- `fire = all_held && addr_eq && out_free`. On fire:
  - load `out_data` = {`INFO_UV`, child 0 address, sum}.
  - set `out_valid`.
  - clear every `held`.
- `mismatch = all_held && !addr_eq`. On mismatch:
  - clear every `held`.
  - pulse `err_mismatch` next cycle.
  - count one drop event.
  - no output is produced.
- `in_ready[i] = !held[i] || fire || mismatch`. This path is combinational, from `out_ready`. A new packet may be captured on the same edge that clears the old one.
- Output register: `out_valid` clears when `out_ready && !fire`. It holds `out_data` stable while `out_valid && !out_ready`.
- Sum arithmetic:
  - Sign-extend every data field to `DATA_WIDTH+clog2(NUM_CHILD)` bits and add.
  - `SAT=0`: keep the low `DATA_WIDTH` bits.
  - `SAT=1`: clamp to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
- `drop_cnt` adds the number of drop events in the cycle. That is up to `NUM_CHILD` non-UV discards plus one mismatch. It saturates at 16'hFFFF and never wraps.

## Timing
- Reset (`rst_n` low at an edge): `held`=0, `out_valid`=0, `out_data`=0, `err_mismatch`=0, `drop_cnt`=0. A packet presented during reset is lost.
- Latency: the last child handshake in cycle T sets `held` at edge T+1. Fire occurs in cycle T+1, and `out_valid`/`out_data` appear in cycle T+2.
- Throughput: one merge per cycle when all children present every cycle and `out_ready`=1.
- Backpressure: if `out_valid && !out_ready`, no fire occurs, held packets stay, and `in_ready` stays low for held children.
- A child may present up to one packet early. A second packet from the same child waits until fire or mismatch.
- Simultaneous non-UV discards on k children in the same cycle: `drop_cnt` += k.
- Mismatch takes priority: no fire occurs in a mismatch cycle.

## Test plan
- Aligned merge, `NUM_CHILD`=4, `SAT`=0: data 1, 2, 3, 4, addr 0x0055 on all children in cycle 0 → cycle 2 `out_valid`=1, `out_data` = {UV, 0x0055, 0x000A}.
- Skewed arrival: child 2 arrives 5 cycles after the others → output 2 cycles after child 2's handshake. `in_ready` for the early children is low until fire.
- Saturation: all data 0x7000, `SAT`=1 → sum 0x7FFF. With `SAT`=0 → 0xC000. All data 0x8000, `SAT`=1 → 0x8000.
- Backpressure: hold `out_ready`=0 for 4 cycles with a second full set arriving → `out_data` stays stable, second set held, `in_ready`=0. Raise `out_ready` → first packet transfers and the second fires on the same edge.
- Mismatch and drops: child 3 addr 0x0056 vs 0x0055 → no output, `err_mismatch` pulse, `drop_cnt`=1. Then non-UV info on children 0 and 1 in the same cycle → `drop_cnt`=3.
- Reset mid-operation: assert `rst_n`=0 with 3 children held and `out_valid`=1 → all outputs at reset values next cycle. A fresh aligned set then merges normally.
